// File: rtl/qconv_stage_sequencer_pkg.sv
// Shared definitions for the qconv stage sequencer: FSM state type and index-width helper.
package qconv_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_ERR   = 2'd3
  } seq_state_e;

  // A single stage still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qconv_stage_sequencer_watchdog.sv
// Per-stage watchdog: counts enabled cycles up to a limit; a limit of zero disables expiry.
module qconv_watchdog #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  // Saturates at the limit so a stalled FSM cannot wrap the counter past expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/qconv_stage_sequencer.sv
// Issues start pulses to each stage FSM in order per tile, waits for each finish,
// and reports run completion, abort and watchdog expiry.
module qconv_stage_sequencer
  import qconv_stage_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES  = 3,
  parameter int unsigned TILE_W    = 16,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [TILE_W-1:0]                num_tiles,
  input  logic [TIMEOUT_W-1:0]             timeout,
  input  logic [N_STAGES-1:0]              stage_finish,
  output logic [N_STAGES-1:0]              stage_start,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [TILE_W-1:0]                tile_idx,
  output logic [idx_width(N_STAGES)-1:0]   stage_idx
);

  localparam int unsigned STAGE_W = idx_width(N_STAGES);

  seq_state_e           state, state_next;
  logic [STAGE_W-1:0]   stage_next;
  logic [TILE_W-1:0]    tile_next;
  logic [TILE_W-1:0]    num_tiles_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic                 done_next, error_next, load_cfg;
  logic                 wd_clear, wd_enable, wd_expired;
  logic                 finish_cur, last_stage, last_tile;

  qconv_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (timeout_q),
    .expired (wd_expired)
  );

  assign finish_cur = stage_finish[stage_idx];
  assign last_stage = (stage_idx == STAGE_W'(N_STAGES - 1));
  assign last_tile  = (tile_idx == (num_tiles_q - TILE_W'(1)));

  always_comb begin
    state_next = state;
    stage_next = stage_idx;
    tile_next  = tile_idx;
    done_next  = 1'b0;
    error_next = error;
    load_cfg   = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    unique case (state)
      SEQ_IDLE, SEQ_ERR: begin
        if (abort) begin
          state_next = SEQ_IDLE;
        end else if (start) begin
          load_cfg   = 1'b1;
          error_next = 1'b0;
          stage_next = '0;
          tile_next  = '0;
          if (num_tiles == '0) begin
            done_next  = 1'b1;
            state_next = SEQ_IDLE;
          end else begin
            state_next = SEQ_ISSUE;
          end
        end
      end
      SEQ_ISSUE: begin
        wd_clear = 1'b1;
        state_next = abort ? SEQ_IDLE : SEQ_WAIT;
      end
      SEQ_WAIT: begin
        wd_enable = 1'b1;
        // Priority: abort, then finish, then watchdog expiry.
        if (abort) begin
          state_next = SEQ_IDLE;
        end else if (finish_cur) begin
          if (!last_stage) begin
            stage_next = stage_idx + 1'b1;
            state_next = SEQ_ISSUE;
          end else if (!last_tile) begin
            stage_next = '0;
            tile_next  = tile_idx + 1'b1;
            state_next = SEQ_ISSUE;
          end else begin
            done_next  = 1'b1;
            state_next = SEQ_IDLE;
          end
        end else if (wd_expired) begin
          error_next = 1'b1;
          state_next = SEQ_ERR;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEQ_IDLE;
      stage_idx   <= '0;
      tile_idx    <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      num_tiles_q <= '0;
      timeout_q   <= '0;
    end else begin
      state       <= state_next;
      stage_idx   <= stage_next;
      tile_idx    <= tile_next;
      stage_start <= (state_next == SEQ_ISSUE) ? (N_STAGES'(1) << stage_next) : '0;
      busy        <= (state_next == SEQ_ISSUE) || (state_next == SEQ_WAIT);
      done        <= done_next;
      error       <= error_next;
      if (load_cfg) begin
        num_tiles_q <= num_tiles;
        timeout_q   <= timeout;
      end
    end
  end

endmodule
